alu_issue_stage: RTL

//  Execute-side issue register that drives the 16-bit ALU's ctrl/A/B inputs. Accepts decoded ops and

---
 rtl/alu_issue_stage.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Issue register in front of the 16-bit ALU. It maps decoded ops to
//            the ALU ctrl code and operands, and uses a 1-entry skid buffer so
//            that in_ready comes straight from a register.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int W      = 16,
    parameter int CTRL_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [W-1:0]      in_rx,
    input  logic [W-1:0]      in_ry,
    input  logic [7:0]        in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic              illegal,
    output logic [15:0]       issue_cnt
);

    localparam logic [4:0] c_LAST_LEGAL_OP = 5'd18;

    logic [CTRL_W-1:0] w_ctrl;
    logic [W-1:0]      w_a;
    logic [W-1:0]      w_b;
    logic [W-1:0]      w_sx8;
    logic [W-1:0]      w_zx8;
    logic [W-1:0]      w_sh3;
    logic              w_legal;
    logic              w_acc;
    logic              w_acc_legal;
    logic              w_main_free;
    logic              w_out_fire;

    logic              r_out_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic              r_skid_valid;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [W-1:0]      r_skid_a;
    logic [W-1:0]      r_skid_b;
    logic              r_illegal;
    logic [15:0]       r_issue_cnt;

    assign w_sx8 = {{(W-8){in_imm[7]}}, in_imm};
    assign w_zx8 = {{(W-8){1'b0}}, in_imm};
    assign w_sh3 = {{(W-3){1'b0}}, in_imm[2:0]};

    // Shift-by-immediate ops pass sh3 unchanged; the ALU treats 0 as a shift of 8.
    always_comb begin
        w_ctrl = '0;
        w_a    = in_rx;
        w_b    = in_ry;
        unique case (in_op)
            5'd0:  begin w_ctrl = CTRL_W'(1);  w_a = '0;    w_b = in_ry; end
            5'd1:  begin w_ctrl = CTRL_W'(2);  end
            5'd2:  begin w_ctrl = CTRL_W'(2);  w_b = w_sx8; end
            5'd3:  begin w_ctrl = CTRL_W'(3);  end
            5'd4:  begin w_ctrl = CTRL_W'(4);  end
            5'd5:  begin w_ctrl = CTRL_W'(5);  end
            5'd6:  begin w_ctrl = CTRL_W'(6);  w_a = in_ry; w_b = '0;    end
            5'd7:  begin w_ctrl = CTRL_W'(7);  end
            5'd8:  begin w_ctrl = CTRL_W'(8);  end
            5'd9:  begin w_ctrl = CTRL_W'(9);  end
            5'd10: begin w_ctrl = CTRL_W'(10); end
            5'd11: begin w_ctrl = CTRL_W'(11); w_a = in_ry; w_b = w_sh3; end
            5'd12: begin w_ctrl = CTRL_W'(12); end
            5'd13: begin w_ctrl = CTRL_W'(13); end
            5'd14: begin w_ctrl = CTRL_W'(14); w_a = in_ry; w_b = w_sh3; end
            5'd15: begin w_ctrl = CTRL_W'(15); w_a = in_ry; w_b = w_sh3; end
            5'd16: begin w_ctrl = CTRL_W'(16); end
            5'd17: begin w_ctrl = CTRL_W'(16); w_b = w_sx8; end
            5'd18: begin w_ctrl = CTRL_W'(1);  w_a = '0;    w_b = w_zx8; end
            default: begin w_ctrl = '0; w_a = '0; w_b = '0; end
        endcase
    end

    assign w_legal     = (in_op <= c_LAST_LEGAL_OP);
    assign w_acc       = in_valid & in_ready & ~flush;
    assign w_acc_legal = w_acc & w_legal;
    assign w_main_free = ~r_out_valid | out_ready;
    assign w_out_fire  = r_out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_ctrl       <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_a     <= '0;
            r_skid_b     <= '0;
            r_illegal    <= 1'b0;
            r_issue_cnt  <= '0;
        end else begin
            if (w_out_fire)
                r_issue_cnt <= r_issue_cnt + 16'd1;
            if (w_acc & ~w_legal)
                r_illegal <= 1'b1;

            // Flush clears only the valid flags; payload registers keep their contents.
            if (flush) begin
                r_out_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (w_main_free) begin
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_ctrl       <= r_skid_ctrl;
                    r_a          <= r_skid_a;
                    r_b          <= r_skid_b;
                    r_skid_valid <= w_acc_legal;
                    if (w_acc_legal) begin
                        r_skid_ctrl <= w_ctrl;
                        r_skid_a    <= w_a;
                        r_skid_b    <= w_b;
                    end
                end else if (w_acc_legal) begin
                    r_out_valid <= 1'b1;
                    r_ctrl      <= w_ctrl;
                    r_a         <= w_a;
                    r_b         <= w_b;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_acc_legal) begin
                r_skid_valid <= 1'b1;
                r_skid_ctrl  <= w_ctrl;
                r_skid_a     <= w_a;
                r_skid_b     <= w_b;
            end
        end
    end

    assign in_ready  = ~r_skid_valid;
    assign out_valid = r_out_valid;
    assign alu_ctrl  = r_ctrl;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign illegal   = r_illegal;
    assign issue_cnt = r_issue_cnt;

endmodule
`default_nettype wire
